inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 27 ++
 rtl/inst_fetch.sv | 132 +++++++++++++
 tb/tb_inst_fetch.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared defines and helpers for the instruction-fetch stage.
// Compiled ahead of every other file so the macros are visible there.
`ifndef INST_FETCH_DEFINES
`define INST_FETCH_DEFINES
`define RstEnable     1'b1
`define ZeroWord      32'h00000000
`define InstAddrBus   31:0
`define InstBus       31:0
`define InstStepBytes 32'd4
`endif

package inst_fetch_pkg;

    function automatic logic [`InstAddrBus] align_word(
        input logic [`InstAddrBus] a
    );
        return {a[31:2], 2'b00};
    endfunction

    // Wraps modulo 2^32 by construction.
    function automatic logic [`InstAddrBus] next_pc(
        input logic [`InstAddrBus] a
    );
        return a + `InstStepBytes;
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: one outstanding request, one-entry skid on stall,
// branch redirect with kill of an in-flight request.
module inst_fetch
    import inst_fetch_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_flag,
    input  logic [`InstAddrBus] branch_target_address,
    output logic                inst_req,
    output logic [`InstAddrBus] inst_addr,
    input  logic                inst_ack,
    input  logic [`InstBus]     inst_rdata,
    output logic [`InstAddrBus] if_pc,
    output logic [`InstBus]     if_inst,
    output logic                if_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        KILL  = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                req_q, req_d;
    logic [`InstAddrBus] addr_q, addr_d;
    logic [`InstAddrBus] pc_q, pc_d;
    logic [`InstBus]     inst_q, inst_d;
    logic                valid_q, valid_d;
    logic [`InstBus]     skid_q, skid_d;
    logic [`InstAddrBus] tgt_q, tgt_d;
    logic [`InstAddrBus] tgt_a;
    logic                busy;

    assign tgt_a = align_word(branch_target_address);
    assign busy  = (state_q == FETCH) || (state_q == KILL);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        skid_d  = skid_q;
        tgt_d   = tgt_q;
        if (branch_flag) begin
            valid_d = 1'b0;
            inst_d  = `ZeroWord;
            skid_d  = `ZeroWord;
            if (busy && !inst_ack) begin
                state_d = KILL;
                tgt_d   = tgt_a;
            end else begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = tgt_a;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = `ZeroWord;
                end
                FETCH: begin
                    if (inst_ack && !stall) begin
                        pc_d    = addr_q;
                        inst_d  = inst_rdata;
                        valid_d = 1'b1;
                        addr_d  = next_pc(addr_q);
                    end else if (inst_ack) begin
                        // addr_q keeps the skid entry's PC while held
                        skid_d  = inst_rdata;
                        req_d   = 1'b0;
                        state_d = HOLD;
                    end
                end
                KILL: begin
                    if (inst_ack) begin
                        state_d = FETCH;
                        addr_d  = tgt_q;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        pc_d    = addr_q;
                        inst_d  = skid_q;
                        valid_d = 1'b1;
                        skid_d  = `ZeroWord;
                        addr_d  = next_pc(addr_q);
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst == `RstEnable) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= `ZeroWord;
            pc_q    <= `ZeroWord;
            inst_q  <= `ZeroWord;
            valid_q <= 1'b0;
            skid_q  <= `ZeroWord;
            tgt_q   <= `ZeroWord;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            skid_q  <= skid_d;
            tgt_q   <= tgt_d;
        end
    end

    assign inst_req  = req_q;
    assign inst_addr = addr_q;
    assign if_pc     = pc_q;
    assign if_inst   = inst_q;
    assign if_valid  = valid_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic
// checked against a transaction-level fetch model.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst, stall, branch_flag, inst_ack;
    logic [31:0] branch_target_address, inst_rdata;
    logic        inst_req, if_valid;
    logic [31:0] inst_addr, if_pc, if_inst;

    always #5 clk = ~clk;

    inst_fetch dut (
        .clk                   (clk),
        .rst                   (rst),
        .stall                 (stall),
        .branch_flag           (branch_flag),
        .branch_target_address (branch_target_address),
        .inst_req              (inst_req),
        .inst_addr             (inst_addr),
        .inst_ack              (inst_ack),
        .inst_rdata            (inst_rdata),
        .if_pc                 (if_pc),
        .if_inst               (if_inst),
        .if_valid              (if_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [97:0] dut_vec;
    assign dut_vec = {inst_req, inst_addr, if_pc, if_inst, if_valid};

    // model: outstanding request, pending redirect, queue of held words
    logic        m_req, m_valid, m_fresh, m_discard;
    logic [31:0] m_addr, m_pc, m_inst, m_tgt;
    logic [31:0] m_skid[$];

    function automatic logic [97:0] expv();
        return {m_req, m_addr, m_pc, m_inst, m_valid};
    endfunction

    task automatic model_step();
        logic [31:0] t;
        t = branch_target_address & 32'hFFFF_FFFC;
        if (rst) begin
            {m_req, m_valid, m_discard} = '0;
            {m_addr, m_pc, m_inst, m_tgt} = '0;
            m_fresh = 1'b1;
            m_skid.delete();
        end else if (branch_flag) begin
            m_valid = 1'b0;
            m_inst  = 0;
            m_skid.delete();
            if (m_req && !inst_ack) begin
                m_discard = 1'b1;
                m_tgt = t;
            end else begin
                m_discard = 1'b0;
                m_req  = 1'b1;
                m_addr = t;
            end
            m_fresh = 1'b0;
        end else if (m_fresh) begin
            m_fresh = 1'b0;
            m_req  = 1'b1;
            m_addr = 0;
        end else if (m_req && m_discard) begin
            if (inst_ack) begin
                m_discard = 1'b0;
                m_addr = m_tgt;
            end
        end else if (m_req && inst_ack) begin
            if (!stall) begin
                m_pc    = m_addr;
                m_inst  = inst_rdata;
                m_valid = 1'b1;
                m_addr  = m_addr + 4;
            end else begin
                m_skid.push_back(inst_rdata);
                m_req = 1'b0;
            end
        end else if (!m_req && m_skid.size() > 0 && !stall) begin
            m_pc    = m_addr;
            m_inst  = m_skid.pop_front();
            m_valid = 1'b1;
            m_addr  = m_addr + 4;
            m_req   = 1'b1;
        end
    endtask

    task automatic tick(
        input logic r, s, b,
        input logic [31:0] t,
        input logic a,
        input logic [31:0] d
    );
        rst = r; stall = s; branch_flag = b;
        branch_target_address = t;
        inst_ack = a; inst_rdata = d;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1, 1'($urandom), 1'($urandom), $urandom,
                 1'($urandom), $urandom);
            n_vec++;
            if (dut_vec !== 98'b0) begin
                n_err++;
                $display("FAIL reset: got %h want 0", dut_vec);
            end
        end
    endtask

    task automatic test_zero_wait();
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick(0, 0, 0, 0, 1, $urandom);
            n_vec++;
            if (i == 0 && (inst_req !== 1'b1 || inst_addr !== 0
                           || if_valid !== 1'b0)) begin
                n_err++;
                $display("FAIL zw_first: req=%b addr=%h v=%b want 1 0 0",
                         inst_req, inst_addr, if_valid);
            end else if (i > 0 && (if_pc !== 32'((i - 1) * 4)
                                   || if_valid !== 1'b1)) begin
                n_err++;
                $display("FAIL zw_pc: got %h/%b want %h/1",
                         if_pc, if_valid, 32'((i - 1) * 4));
            end
        end
    endtask

    task automatic test_delayed_ack();
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 32'hA000_0000);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0, $urandom);
            n_vec++;
            if (inst_req !== 1'b1 || inst_addr !== 32'h4
                || if_pc !== 0 || if_valid !== 1'b1) begin
                n_err++;
                $display("FAIL dly_hold: req=%b addr=%h pc=%h v=%b",
                         inst_req, inst_addr, if_pc, if_valid);
            end
        end
        tick(0, 0, 0, 0, 1, 32'hA000_0004);
        n_vec++;
        if (if_pc !== 32'h4 || if_inst !== 32'hA000_0004
            || inst_addr !== 32'h8) begin
            n_err++;
            $display("FAIL dly_ack: pc=%h inst=%h addr=%h want 4 A0000004 8",
                     if_pc, if_inst, inst_addr);
        end
    endtask

    task automatic test_stall();
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 32'hB000_0000);
        tick(0, 0, 0, 0, 1, 32'hB000_0004);
        tick(0, 1, 0, 0, 1, 32'hB000_0008);
        tick(0, 1, 0, 0, 0, $urandom);
        n_vec++;
        if (if_pc !== 32'h4 || if_inst !== 32'hB000_0004
            || if_valid !== 1'b1 || inst_req !== 1'b0) begin
            n_err++;
            $display("FAIL stall_frz: pc=%h inst=%h v=%b req=%b",
                     if_pc, if_inst, if_valid, inst_req);
        end
        tick(0, 0, 0, 0, 0, $urandom);
        n_vec++;
        if (if_pc !== 32'h8 || if_inst !== 32'hB000_0008
            || inst_req !== 1'b1 || inst_addr !== 32'hC) begin
            n_err++;
            $display("FAIL stall_rel: pc=%h inst=%h req=%b addr=%h",
                     if_pc, if_inst, inst_req, inst_addr);
        end
    endtask

    task automatic test_branch_kill();
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            tick(0, 0, 0, 0, 1, $urandom);
        tick(0, 0, 1, 32'h103, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        n_vec++;
        if (if_valid !== 1'b0 || if_inst !== 0
            || inst_addr !== 32'h10 || inst_req !== 1'b1) begin
            n_err++;
            $display("FAIL br_kill: v=%b inst=%h addr=%h req=%b",
                     if_valid, if_inst, inst_addr, inst_req);
        end
        tick(0, 0, 0, 0, 1, 32'hDEAD_0010);
        n_vec++;
        if (if_valid !== 1'b0 || if_inst !== 0
            || inst_addr !== 32'h100) begin
            n_err++;
            $display("FAIL br_drop: v=%b inst=%h addr=%h want 0 0 100",
                     if_valid, if_inst, inst_addr);
        end
    endtask

    task automatic test_wrap();
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 32'hFFFF_FFFE, 0, 0);
        tick(0, 0, 0, 0, 1, 32'h1234_5678);
        n_vec++;
        if (inst_addr !== 0 || if_pc !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL wrap: addr=%h pc=%h want 0 FFFFFFFC",
                     inst_addr, if_pc);
        end
    endtask

    task automatic test_reset_mid();
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 1, 32'hC000_0000);
        tick(1, 0, 0, 0, 0, 0);
        n_vec++;
        if (dut_vec !== 98'b0) begin
            n_err++;
            $display("FAIL rst_mid: got %h want 0", dut_vec);
        end
        tick(0, 0, 0, 0, 1, 32'hC000_0004);
        n_vec++;
        if (inst_req !== 1'b1 || inst_addr !== 0 || if_valid !== 1'b0
            || if_inst !== 0) begin
            n_err++;
            $display("FAIL rst_late: req=%b addr=%h v=%b inst=%h",
                     inst_req, inst_addr, if_valid, if_inst);
        end
        tick(0, 0, 0, 0, 1, 32'hC000_0000);
        n_vec++;
        if (if_pc !== 0 || if_inst !== 32'hC000_0000
            || if_valid !== 1'b1) begin
            n_err++;
            $display("FAIL rst_restart: pc=%h inst=%h v=%b",
                     if_pc, if_inst, if_valid);
        end
    endtask

    task automatic test_random();
        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(99) == 0),
                 ($urandom_range(3) == 0),
                 ($urandom_range(9) == 0),
                 $urandom,
                 1'($urandom),
                 $urandom);
            n_vec++;
            if (dut_vec !== expv()) begin
                n_err++;
                $display("FAIL rand[%0d]: got %h want %h",
                         i, dut_vec, expv());
            end
        end
    endtask

    initial begin
        m_fresh = 1'b1;
        m_discard = 1'b0;
        test_reset();
        test_zero_wait();
        test_delayed_ack();
        test_stall();
        test_branch_kill();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
